// File: rtl/ttu_track_scheduler.sv
// ttu_track_scheduler: round-robin arbiter that time-shares one target
// tracking unit (TTU) among NUM_REQ fire-control requesters. It supervises
// each job through ack and result timeouts, pulses the TTU reset when a job
// hangs, and holds a guard gap between radar shots.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// S_IDLE     | no job; picks the next pending requester round-robin
// S_CMD      | track command high this cycle; arms the ack timer
// S_WAIT_ACK | waiting for the TTU to enter TRANSMIT
// S_WAIT_RES | waiting for LOCKED (OK) or IDLE (MISS)
// S_RECOVER  | TTU reset pulse high; emits the TIMEOUT result
// S_GUARD    | quiet gap before the next command
module ttu_track_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = 2,
  parameter int ACK_TIMEOUT    = 4,
  parameter int RESULT_TIMEOUT = 1000,
  parameter int GUARD_CYCLES   = 2,
  parameter int CNT_W          = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic               busy,
  output logic [ID_W-1:0]    grant_id,
  output logic               result_valid,
  output logic [ID_W-1:0]    result_id,
  output logic [13:0]        result_distance,
  output logic [1:0]         result_status,
  output logic               ttu_track_cmd,
  output logic               ttu_rst,
  input  logic [1:0]         ttu_state,
  input  logic               ttu_target_locked,
  input  logic [13:0]        ttu_distance
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_WAIT_ACK,
    S_WAIT_RES,
    S_RECOVER,
    S_GUARD
  } state_t;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_MISS    = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  localparam logic [1:0] TTU_IDLE     = 2'b00;
  localparam logic [1:0] TTU_TRANSMIT = 2'b01;
  localparam logic [1:0] TTU_LOCKED   = 2'b11;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   pending_q, pending_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [ID_W-1:0]      grant_id_q, grant_id_d;
  logic                 busy_q, busy_d;
  logic                 cmd_q, cmd_d;
  logic                 ttu_rst_q, ttu_rst_d;
  logic                 res_valid_q, res_valid_d;
  logic [ID_W-1:0]      res_id_q, res_id_d;
  logic [13:0]          res_dist_q, res_dist_d;
  logic [1:0]           res_status_q, res_status_d;

  logic [2*NUM_REQ-1:0] pend_dbl;
  logic [NUM_REQ-1:0]   pend_rot;
  logic [ID_W:0]        rr_start;
  logic [ID_W:0]        rr_off;
  logic [ID_W:0]        rr_sum;
  logic                 rr_found;
  logic [ID_W-1:0]      rr_pick;
  logic [NUM_REQ-1:0]   rr_mask;

  // Round-robin pick: rotate pending so bit 0 is ptr+1, take the lowest set bit.
  always_comb begin
    rr_start = {1'b0, ptr_q} + (ID_W+1)'(1);
    pend_dbl = {pending_q, pending_q};
    pend_rot = NUM_REQ'(pend_dbl >> rr_start);
    rr_found = 1'b0;
    rr_off   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (pend_rot[k]) begin
        rr_found = 1'b1;
        rr_off   = (ID_W+1)'(k);
      end
    end
    rr_sum = rr_start + rr_off;
    if (rr_sum >= (ID_W+1)'(NUM_REQ)) begin
      rr_sum = rr_sum - (ID_W+1)'(NUM_REQ);
    end
    rr_pick = rr_sum[ID_W-1:0];
    rr_mask = NUM_REQ'(1) << rr_pick;
  end

  // Next-state and registered-output logic for the job sequencer.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pending_d    = pending_q | req;
    ptr_d        = ptr_q;
    grant_id_d   = grant_id_q;
    busy_d       = busy_q;
    cmd_d        = 1'b0;
    ttu_rst_d    = 1'b0;
    res_valid_d  = 1'b0;
    res_id_d     = res_id_q;
    res_dist_d   = res_dist_q;
    res_status_d = res_status_q;

    case (state_q)
      S_IDLE: begin
        if (rr_found) begin
          // A request arriving on the same cycle as the clear re-queues the bit.
          pending_d  = (pending_q & ~rr_mask) | req;
          grant_id_d = rr_pick;
          ptr_d      = rr_pick;
          busy_d     = 1'b1;
          cmd_d      = 1'b1;
          state_d    = S_CMD;
        end
      end

      S_CMD: begin
        cnt_d   = CNT_W'(ACK_TIMEOUT);
        state_d = S_WAIT_ACK;
      end

      S_WAIT_ACK: begin
        if (ttu_state == TTU_TRANSMIT) begin
          cnt_d   = CNT_W'(RESULT_TIMEOUT);
          state_d = S_WAIT_RES;
        end else if (cnt_q <= CNT_W'(1)) begin
          ttu_rst_d = 1'b1;
          state_d   = S_RECOVER;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_WAIT_RES: begin
        if (ttu_state == TTU_LOCKED && ttu_target_locked) begin
          res_valid_d  = 1'b1;
          res_id_d     = grant_id_q;
          res_dist_d   = ttu_distance;
          res_status_d = ST_OK;
        end else if (ttu_state == TTU_IDLE) begin
          res_valid_d  = 1'b1;
          res_id_d     = grant_id_q;
          res_dist_d   = '0;
          res_status_d = ST_MISS;
        end else if (cnt_q <= CNT_W'(1)) begin
          ttu_rst_d = 1'b1;
          state_d   = S_RECOVER;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_RECOVER: begin
        res_valid_d  = 1'b1;
        res_id_d     = grant_id_q;
        res_dist_d   = '0;
        res_status_d = ST_TIMEOUT;
      end

      S_GUARD: begin
        if (cnt_q <= CNT_W'(1)) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    // Every result hands over to the guard gap, or straight to IDLE if it is zero.
    if (res_valid_d) begin
      if (GUARD_CYCLES == 0) begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end else begin
        cnt_d   = CNT_W'(GUARD_CYCLES);
        state_d = S_GUARD;
      end
    end
  end

  // State and output registers; reset aborts any job without a result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      pending_q    <= '0;
      ptr_q        <= ID_W'(NUM_REQ - 1);
      grant_id_q   <= '0;
      busy_q       <= 1'b0;
      cmd_q        <= 1'b0;
      ttu_rst_q    <= 1'b0;
      res_valid_q  <= 1'b0;
      res_id_q     <= '0;
      res_dist_q   <= '0;
      res_status_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pending_q    <= pending_d;
      ptr_q        <= ptr_d;
      grant_id_q   <= grant_id_d;
      busy_q       <= busy_d;
      cmd_q        <= cmd_d;
      ttu_rst_q    <= ttu_rst_d;
      res_valid_q  <= res_valid_d;
      res_id_q     <= res_id_d;
      res_dist_q   <= res_dist_d;
      res_status_q <= res_status_d;
    end
  end

  assign busy            = busy_q;
  assign grant_id        = grant_id_q;
  assign result_valid    = res_valid_q;
  assign result_id       = res_id_q;
  assign result_distance = res_dist_q;
  assign result_status   = res_status_q;
  assign ttu_track_cmd   = cmd_q;
  assign ttu_rst         = ttu_rst_q;

endmodule

// File: tb/tb_ttu_track_scheduler.sv
// Directed bench for ttu_track_scheduler with a behavioural TTU model and a
// result scoreboard (expected pushed at stimulus, popped on result_valid).
module tb_ttu_track_scheduler;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_MISS    = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  localparam int M_OK    = 0;
  localparam int M_MISS  = 1;
  localparam int M_NOACK = 2;
  localparam int M_STUCK = 3;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic        busy;
  logic [1:0]  grant_id;
  logic        result_valid;
  logic [1:0]  result_id;
  logic [13:0] result_distance;
  logic [1:0]  result_status;
  logic        ttu_track_cmd;
  logic        ttu_rst;
  logic [1:0]  ttu_state;
  logic        ttu_target_locked;
  logic [13:0] ttu_distance;

  ttu_track_scheduler dut (
    .clk               (clk),
    .rst               (rst),
    .req               (req),
    .busy              (busy),
    .grant_id          (grant_id),
    .result_valid      (result_valid),
    .result_id         (result_id),
    .result_distance   (result_distance),
    .result_status     (result_status),
    .ttu_track_cmd     (ttu_track_cmd),
    .ttu_rst           (ttu_rst),
    .ttu_state         (ttu_state),
    .ttu_target_locked (ttu_target_locked),
    .ttu_distance      (ttu_distance)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  logic [17:0] exp_q[$];
  logic [17:0] obs_q[$];

  int         cmd_cnt  = 0;
  int         cmd_cyc  = 0;
  logic [1:0] cmd_gid  = '0;
  int         trst_cnt = 0;
  int         trst_cyc = 0;
  int         res_cnt  = 0;
  int         res_cyc  = 0;
  int         dbl_cmd  = 0;
  bit         outstanding = 0;

  int mode     = M_OK;
  int ack_dly  = 2;
  int lock_dly = 38;

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (ttu_track_cmd) begin
      cmd_cnt++;
      cmd_cyc = cyc;
      cmd_gid = grant_id;
      if (outstanding) dbl_cmd++;
      outstanding = 1;
    end
    if (ttu_rst) begin
      trst_cnt++;
      trst_cyc = cyc;
    end
    if (result_valid) begin
      obs_q.push_back({result_id, result_status, result_distance});
      res_cnt++;
      res_cyc = cyc;
      outstanding = 0;
    end
    if (rst) outstanding = 0;
  end

  // TTU model: t counts cycles since the command cycle.
  initial begin : ttu_model
    int  t;
    bit  on;
    t = 0;
    on = 0;
    ttu_state = 2'b00;
    ttu_target_locked = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst || ttu_rst) begin
        on = 0;
        ttu_state = 2'b00;
      end else if (ttu_track_cmd) begin
        on = 1;
        t = 0;
      end else if (on) begin
        t++;
        case (mode)
          M_OK: begin
            if (t >= lock_dly + 2) begin ttu_state = 2'b00; on = 0; end
            else if (t >= lock_dly) ttu_state = 2'b11;
            else if (t > ack_dly) ttu_state = 2'b10;
            else if (t == ack_dly) ttu_state = 2'b01;
          end
          M_MISS: begin
            if (t >= ack_dly + 5) begin ttu_state = 2'b00; on = 0; end
            else if (t >= ack_dly + 2) ttu_state = 2'b10;
            else if (t >= ack_dly) ttu_state = 2'b01;
          end
          M_STUCK: begin
            if (t > ack_dly) ttu_state = 2'b10;
            else if (t == ack_dly) ttu_state = 2'b01;
          end
          default: ttu_state = 2'b00;
        endcase
      end
      ttu_target_locked = (ttu_state == 2'b11);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [3:0] v);
    req = v;
    tick();
    req = '0;
  endtask

  task automatic wait_cmd(input string tag, input int budget);
    int c0;
    int n;
    c0 = cmd_cnt;
    n = 0;
    while (cmd_cnt == c0 && n < budget) begin tick(); n++; end
    chk({tag, "_cmd_seen"}, 32'(cmd_cnt != c0), 1);
  endtask

  task automatic wait_result(input string tag, input int budget);
    int n;
    logic [17:0] o;
    logic [17:0] e;
    n = 0;
    while (obs_q.size() == 0 && n < budget) begin tick(); n++; end
    chk({tag, "_arrived"}, 32'(obs_q.size() != 0), 1);
    if (obs_q.size() != 0) begin
      o = obs_q.pop_front();
      if (exp_q.size() != 0) e = exp_q.pop_front();
      else e = '1;
      chk({tag, "_id"},     32'(o[17:16]), 32'(e[17:16]));
      chk({tag, "_status"}, 32'(o[15:14]), 32'(e[15:14]));
      chk({tag, "_dist"},   32'(o[13:0]),  32'(e[13:0]));
    end
  endtask

  initial begin : stim
    int req_cyc;
    int prev_res;
    int t0;
    int r0;
    int c1;
    logic [1:0] rr_ids [5];
    rr_ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    // 1: reset with all requests high
    rst = 1'b1;
    req = 4'b1111;
    ttu_distance = 14'd570;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_outputs", 32'({busy, grant_id, result_valid, result_id, result_distance,
                              result_status, ttu_track_cmd, ttu_rst}), 0);
    end
    rst = 1'b0;
    req = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_no_pending", 32'(busy), 0);
    end
    chk("rst_no_cmd", 32'(cmd_cnt), 0);

    // 2: single OK job
    mode = M_OK; ack_dly = 2; lock_dly = 38;
    exp_q.push_back({2'd0, ST_OK, 14'd570});
    req_cyc = cyc;
    pulse(4'b0001);
    wait_result("t2", 200);
    chk("t2_cmd_latency", 32'(cmd_cyc - req_cyc), 2);
    chk("t2_cmd_gid", 32'(cmd_gid), 0);
    chk("t2_res_latency", 32'(res_cyc - cmd_cyc), 39);
    chk("t2_busy_in_guard", 32'(busy), 1);
    chk("t2_valid_one_cycle", 32'(result_valid), 0);
    chk("t2_dist_held", 32'(result_distance), 570);
    tick();
    chk("t2_busy_after_guard", 32'(busy), 0);

    // 3: round robin from reset, req[0] re-pulsed during job 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    ack_dly = 1; lock_dly = 6;
    ttu_distance = 14'h3FFF;
    for (int j = 0; j < 5; j++) exp_q.push_back({rr_ids[j], ST_OK, 14'h3FFF});
    pulse(4'b1111);
    wait_cmd("t3_job0", 20);
    pulse(4'b0001);
    for (int j = 0; j < 5; j++) begin
      prev_res = res_cyc;
      wait_result($sformatf("t3_job%0d", j), 100);
      if (j > 0) chk($sformatf("t3_guard_gap%0d", j), 32'(cmd_cyc - prev_res), 3);
    end

    // 4: miss
    tick(); tick(); tick();
    mode = M_MISS; ack_dly = 2;
    ttu_distance = 14'd999;
    t0 = trst_cnt;
    exp_q.push_back({2'd2, ST_MISS, 14'd0});
    pulse(4'b0100);
    wait_result("t4", 100);
    chk("t4_latency", 32'(res_cyc - cmd_cyc), 8);
    chk("t4_no_ttu_rst", 32'(trst_cnt), 32'(t0));

    // 5a: ack timeout
    tick(); tick(); tick();
    mode = M_NOACK;
    exp_q.push_back({2'd1, ST_TIMEOUT, 14'd0});
    pulse(4'b0010);
    wait_result("t5a", 50);
    chk("t5a_ttu_rst_once", 32'(trst_cnt), 32'(t0 + 1));
    chk("t5a_ttu_rst_cycle", 32'(trst_cyc - cmd_cyc), 5);
    chk("t5a_res_cycle", 32'(res_cyc - cmd_cyc), 6);

    // 5b: result timeout, TTU stuck in LISTEN
    tick(); tick(); tick();
    mode = M_STUCK; ack_dly = 2;
    exp_q.push_back({2'd3, ST_TIMEOUT, 14'd0});
    pulse(4'b1000);
    wait_result("t5b", 1100);
    chk("t5b_ttu_rst_once", 32'(trst_cnt), 32'(t0 + 2));
    chk("t5b_ttu_rst_cycle", 32'(trst_cyc - cmd_cyc), 1003);
    chk("t5b_res_cycle", 32'(res_cyc - cmd_cyc), 1004);

    // 6: reset mid-job with req[2] pending
    tick(); tick(); tick();
    pulse(4'b0001);
    wait_cmd("t6_job", 20);
    pulse(4'b0100);
    for (int i = 0; i < 10; i++) tick();
    r0 = res_cnt;
    c1 = cmd_cnt;
    t0 = trst_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_busy_cleared", 32'(busy), 0);
    mode = M_OK; ack_dly = 2; lock_dly = 10;
    ttu_distance = 14'd4321;
    for (int i = 0; i < 4; i++) tick();
    chk("t6_no_result", 32'(res_cnt), 32'(r0));
    chk("t6_pending_dropped", 32'(cmd_cnt), 32'(c1));
    chk("t6_no_ttu_rst", 32'(trst_cnt), 32'(t0));
    exp_q.push_back({2'd1, ST_OK, 14'd4321});
    pulse(4'b0010);
    wait_result("t6_next", 100);
    chk("t6_next_gid", 32'(cmd_gid), 1);

    chk("sb_empty", 32'(exp_q.size()), 0);
    chk("no_double_cmd", 32'(dbl_cmd), 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
